div_top: RTL and testbench

Iterative RISC-V M-extension divide/remainder unit. It computes DIV, DIVU, REM and REMU and is the counterpart of the M-extension multiplier; both units share the same execute-stage operand and valid handshake. The datapath is a radix-2 restoring divider on operand magnitudes, with sign fix-up at the end. A single operation is in flight at a time, and `busy` stalls issue while it runs.

---
 rtl/div_top.sv | 156 +++++++++++++++
 tb/tb_div_top.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_top.sv
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One operation in flight; busy stalls issue until the result pulse.
module div_top #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            rst_n,
  input  logic [XLEN-1:0] Dividend,
  input  logic [XLEN-1:0] Divisor,
  input  logic [1:0]      Funct,
  input  logic            data_valid_in,
  output logic [XLEN-1:0] data_out,
  output logic            data_valid_out,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN:0]   r_q, r_d;
  logic [XLEN-1:0] q_q, q_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rem_q, rem_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic [XLEN-1:0] out_q, out_d;
  logic            vld_q, vld_d;

  logic            op_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            ovf;
  logic [XLEN:0]   r_sh;
  logic [XLEN+1:0] t;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  // R never exceeds the divisor magnitude, so its guard bit is always 0
  logic unused_r_msb;
  assign unused_r_msb = r_q[XLEN];

  always_comb begin
    op_signed = ~Funct[0];
    a_neg     = op_signed & Dividend[XLEN-1];
    b_neg     = op_signed & Divisor[XLEN-1];
    a_mag     = a_neg ? -Dividend : Dividend;
    b_mag     = b_neg ? -Divisor : Divisor;
    div_zero  = (Divisor == '0);
    ovf       = op_signed & (Dividend == MIN_NEG)
              & (Divisor == '1);
    r_sh      = {r_q[XLEN-1:0], q_q[XLEN-1]};
    t         = {1'b0, r_sh} - {2'b00, dvs_q};
    q_fix     = neg_q_q ? -q_q : q_q;
    r_fix     = neg_r_q ? -r_q[XLEN-1:0] : r_q[XLEN-1:0];
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (data_valid_in) begin
          rem_d = Funct[1];
          cnt_d = '0;
          if (div_zero) begin
            q_d     = '1;
            r_d     = {1'b0, Dividend};
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
            state_d = S_DONE;
          end else if (ovf) begin
            q_d     = Dividend;
            r_d     = '0;
            neg_q_d = 1'b0;
            neg_r_d = 1'b0;
            state_d = S_DONE;
          end else begin
            q_d     = a_mag;
            r_d     = '0;
            dvs_d   = b_mag;
            neg_q_d = a_neg ^ b_neg;
            neg_r_d = a_neg;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        // restore when the trial subtraction borrows
        r_d   = t[XLEN+1] ? r_sh : t[XLEN:0];
        q_d   = {q_q[XLEN-2:0], ~t[XLEN+1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        out_d   = rem_q ? r_fix : q_fix;
        vld_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  assign data_out       = out_q;
  assign data_valid_out = vld_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_div_top.sv
// Bench for div_top: directed table, handshake/reset sequences and
// random operands checked against an arithmetic reference model.
module tb_div_top;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic            CLK = 1'b0;
  logic            rst_n = 1'b0;
  logic [XLEN-1:0] Dividend = '0;
  logic [XLEN-1:0] Divisor = '0;
  logic [1:0]      Funct = '0;
  logic            data_valid_in = 1'b0;
  logic [XLEN-1:0] data_out;
  logic            data_valid_out;
  logic            busy;

  int errors = 0;
  int checks = 0;

  div_top #(.XLEN(XLEN)) dut (
    .CLK(CLK),
    .rst_n(rst_n),
    .Dividend(Dividend),
    .Divisor(Divisor),
    .Funct(Funct),
    .data_valid_in(data_valid_in),
    .data_out(data_out),
    .data_valid_out(data_valid_out),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    if (b == 0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0] && a == MIN_NEG && b == 32'hFFFF_FFFF)
      return f[1] ? 32'h0 : a;
    case (f)
      2'd0: return 32'(sa / sb);
      2'd1: return a / b;
      2'd2: return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] f,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 0) return 1;
    if (!f[0] && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  // Called #1 after the accepting edge; counts edges to the pulse.
  task automatic wait_dv(output logic [31:0] res, output int lat,
                         output bit bad, output bit got);
    res = '0;
    lat = 0;
    bad = 1'b0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(posedge CLK);
      #1;
      lat++;
      if (data_valid_out) begin
        got = 1'b1;
        res = data_out;
        if (busy) bad = 1'b1;
      end else if (!busy) begin
        bad = 1'b1;
      end
    end
  endtask

  task automatic issue(input logic [1:0] f, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge CLK);
    Dividend      = a;
    Divisor       = b;
    Funct         = f;
    data_valid_in = 1'b1;
    @(posedge CLK);
    #1;
    data_valid_in = 1'b0;
    Dividend      = $urandom;
    Divisor       = $urandom;
    Funct         = 2'($urandom_range(0, 3));
  endtask

  task automatic run_op(input string name, input logic [1:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int          lat;
    bit          bad;
    bit          got;
    issue(f, a, b);
    wait_dv(res, lat, bad, got);
    chk({name, "_done"}, 32'(got), 32'd1);
    chk({name, "_data"}, res, exp);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy"}, 32'(bad), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] res;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  f;
    int          lat;
    int          extra;
    bit          bad;
    bit          got;

    tbl.push_back('{2'd0, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33});
    tbl.push_back('{2'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33});
    tbl.push_back('{2'd1, 32'hFFFF_FFFF, 32'h3, 32'h5555_5555, 33});
    tbl.push_back('{2'd3, 32'd100, 32'd7, 32'd2, 33});
    tbl.push_back('{2'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
    tbl.push_back('{2'd3, 32'h1234_5678, 32'd0, 32'h1234_5678, 1});
    tbl.push_back('{2'd0, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG, 1});
    tbl.push_back('{2'd2, MIN_NEG, 32'hFFFF_FFFF, 32'h0, 1});
    tbl.push_back('{2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1});
    tbl.push_back('{2'd1, MIN_NEG, 32'hFFFF_FFFF, 32'h0, 33});
    tbl.push_back('{2'd3, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG, 33});
    tbl.push_back('{2'd0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
    tbl.push_back('{2'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 33});
    tbl.push_back('{2'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, 33});
    tbl.push_back('{2'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 33});
    tbl.push_back('{2'd0, MIN_NEG, 32'd1, MIN_NEG, 33});

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_valid", 32'(data_valid_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge CLK);
    rst_n = 1'b1;

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b,
             tbl[i].exp, tbl[i].lat);

    // request pulsed at E5 while busy must be dropped
    issue(2'd1, 32'd100, 32'd7);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    Dividend      = 32'd999;
    Divisor       = 32'd2;
    Funct         = 2'd0;
    data_valid_in = 1'b1;
    @(posedge CLK);
    #1;
    data_valid_in = 1'b0;
    wait_dv(res, lat, bad, got);
    chk("ign_done", 32'(got), 32'd1);
    chk("ign_data", res, 32'd14);
    chk("ign_lat", 32'(lat + 5), 32'd33);
    extra = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (data_valid_out) extra++;
    end
    chk("ign_no_extra", 32'(extra), 32'd0);

    // request presented in the pulse cycle is accepted
    issue(2'd0, 32'hFFFF_FFF9, 32'h2);
    wait_dv(res, lat, bad, got);
    chk("b2b_first", res, 32'hFFFF_FFFD);
    Dividend      = 32'hFFFF_FFFF;
    Divisor       = 32'd3;
    Funct         = 2'd1;
    data_valid_in = 1'b1;
    @(posedge CLK);
    #1;
    data_valid_in = 1'b0;
    chk("b2b_pulse_len", 32'(data_valid_out), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_dv(res, lat, bad, got);
    chk("b2b_data", res, 32'h5555_5555);
    chk("b2b_lat", 32'(lat), 32'd33);

    // asynchronous reset mid-operation
    issue(2'd0, 32'd1000, 32'd3);
    repeat (9) @(posedge CLK);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(data_valid_out), 32'd0);
    chk("arst_data", data_out, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    rst_n = 1'b1;
    extra = 0;
    repeat (50) begin
      @(posedge CLK);
      #1;
      if (data_valid_out) extra++;
    end
    chk("arst_no_pulse", 32'(extra), 32'd0);
    run_op("arst_fresh", 2'd0, 32'd40, 32'd8, 32'd5, 33);

    for (int n = 0; n < 150; n++) begin
      f = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = MIN_NEG;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        3: b = 32'($urandom_range(1, 20)) ^ 32'hFFFF_FFFF;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op($sformatf("rnd%0d", n), f, a, b, model(f, a, b),
             model_lat(f, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
